// File: rtl/mux_scan_n.sv
// N-channel, W-bit mux with a registered output. Manual mode follows Sel.
// Scan mode steps through the channels and stays DWELL clocks on each one.
module mux_scan_n #(
  parameter  int CHANNELS = 8,
  parameter  int WIDTH    = 1,
  parameter  int DWELL    = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic [SELW-1:0]           Sel,
  input  logic                      Mode,
  input  logic                      Enable,
  output logic [WIDTH-1:0]          S,
  output logic [SELW-1:0]           Cur_sel,
  output logic                      Wrap
);

  localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW-1:0] LAST_CH  = SELW'(CHANNELS - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_cur;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             wrap_q, wrap_d;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= MANUAL;
      cnt_q   <= '0;
      sel_q   <= '0;
      s_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      s_q     <= s_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wrap_d  = 1'b0;
    // Entering scan from manual always begins a fresh dwell on the current channel.
    cnt_cur = (state_q == SCAN) ? cnt_q : '0;
    if (Enable) begin
      state_d = Mode ? SCAN : MANUAL;
      if (!Mode) begin
        cnt_d = '0;
        if (int'(Sel) < CHANNELS) sel_d = Sel;
      end else if (cnt_cur == LAST_CNT) begin
        cnt_d = '0;
        if (sel_q == LAST_CH) begin
          sel_d  = '0;
          wrap_d = 1'b1;
        end else begin
          sel_d = sel_q + SELW'(1);
        end
      end else begin
        cnt_d = cnt_cur + CW'(1);
      end
    end
    // S loads on the same edge as Cur_sel, so the two always agree.
    s_d = Enable ? I[int'(sel_d)*WIDTH +: WIDTH] : s_q;
  end

  assign S       = s_q;
  assign Cur_sel = sel_q;
  assign Wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: a wide 8-channel instance with DWELL=4, and a
// 5-channel instance with DWELL=1. Expected outputs are queued per edge and checked after it.
module tb_mux_scan_n;

  typedef struct packed {
    logic [3:0] s;
    logic [2:0] cs;
    logic       w;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [31:0] Ia;
  logic [19:0] Ib;
  logic [2:0]  Sel;
  logic        Mode, Enable;
  logic [3:0]  Sa, Sb;
  logic [2:0]  CSa, CSb;
  logic        Wa, Wb;

  int checks = 0;
  int failures = 0;
  exp_t qa[$], qb[$];

  always #5 Clock = ~Clock;

  mux_scan_n #(.CHANNELS(8), .WIDTH(4), .DWELL(4)) u_a (
    .Clock(Clock), .Reset_n(Reset_n), .I(Ia), .Sel(Sel), .Mode(Mode),
    .Enable(Enable), .S(Sa), .Cur_sel(CSa), .Wrap(Wa)
  );

  mux_scan_n #(.CHANNELS(5), .WIDTH(4), .DWELL(1)) u_b (
    .Clock(Clock), .Reset_n(Reset_n), .I(Ib), .Sel(Sel), .Mode(Mode),
    .Enable(Enable), .S(Sb), .Cur_sel(CSb), .Wrap(Wb)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed {S,Cur_sel,Wrap}=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ea(input int c, input bit w);
    exp_t e;
    e.s  = Ia[c*4 +: 4];
    e.cs = 3'(c);
    e.w  = w;
    return e;
  endfunction

  function automatic exp_t eb(input int c, input bit w);
    exp_t e;
    e.s  = Ib[c*4 +: 4];
    e.cs = 3'(c);
    e.w  = w;
    return e;
  endfunction

  task automatic push(input exp_t xa, input exp_t xb);
    qa.push_back(xa);
    qb.push_back(xb);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge Clock);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check({tag, "_a"}, {Sa, CSa, Wa}, e);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check({tag, "_b"}, {Sb, CSb, Wb}, e);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, {Sa, CSa, Wa}, 8'h00);
    check({tag, "_b"}, {Sb, CSb, Wb}, 8'h00);
  endtask

  initial begin
    int ca, cb;
    Reset_n = 1'b0;
    Enable  = 1'b1;
    Mode    = 1'b0;
    Sel     = 3'd0;
    for (int k = 0; k < 8; k++) Ia[k*4 +: 4] = 4'(k + 1);
    for (int k = 0; k < 5; k++) Ib[k*4 +: 4] = 4'(k + 9);

    repeat (2) @(posedge Clock);
    #1 check_zero("rst_hold");
    @(negedge Clock);
    Reset_n = 1'b1;
    #1 check_zero("rst_release");

    // Manual selection; out-of-range Sel holds the 5-channel instance.
    Sel = 3'd0; push(ea(0, 0), eb(0, 0)); tick("man0");
    Sel = 3'd5; push(ea(5, 0), eb(0, 0)); tick("man5");
    Sel = 3'd6; push(ea(6, 0), eb(0, 0)); tick("man6");
    Sel = 3'd3; push(ea(3, 0), eb(3, 0)); tick("man3");
    Sel = 3'd7; push(ea(7, 0), eb(3, 0)); tick("man7");
    Sel = 3'd3; push(ea(3, 0), eb(3, 0)); tick("man3b");

    // Scan from channel 3: A dwells 4 clocks, B advances every clock.
    Mode = 1'b1;
    Sel  = 3'd6;
    for (int n = 1; n <= 54; n++) begin
      ca = (3 + n / 4) % 8;
      cb = (3 + n) % 5;
      push(ea(ca, (n % 4 == 0) && (ca == 0)), eb(cb, cb == 0));
      tick("scan");
    end

    // Freeze with A at cnt=2 on channel 0, B on channel 2; inputs change underneath.
    Enable = 1'b0;
    for (int k = 0; k < 8; k++) Ia[k*4 +: 4] = 4'(15 - k);
    for (int k = 0; k < 5; k++) Ib[k*4 +: 4] = 4'(k + 3);
    for (int n = 0; n < 10; n++) begin
      Sel  = 3'($urandom);
      Mode = 1'($urandom);
      push(exp_t'{4'd1, 3'd0, 1'b0}, exp_t'{4'd11, 3'd2, 1'b0});
      tick("freeze");
    end

    Enable = 1'b1;
    Mode   = 1'b1;
    for (int n = 55; n <= 60; n++) begin
      ca = (3 + n / 4) % 8;
      cb = (3 + n) % 5;
      push(ea(ca, (n % 4 == 0) && (ca == 0)), eb(cb, cb == 0));
      tick("resume");
    end

    // Back to manual on the same edge, then re-enter scan from channel 1.
    Mode = 1'b0;
    Sel  = 3'd1;
    push(ea(1, 0), eb(1, 0)); tick("to_man");
    push(ea(1, 0), eb(1, 0)); tick("man1");
    Mode = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      ca = (1 + k / 4) % 8;
      cb = (1 + k) % 5;
      push(ea(ca, 0), eb(cb, cb == 0));
      tick("rescan");
    end

    // Asynchronous reset between edges.
    @(posedge Clock);
    #3 Reset_n = 1'b0;
    #1 check_zero("rst_async");
    @(posedge Clock);
    #1 check_zero("rst_edge");
    @(negedge Clock);
    Reset_n = 1'b1;
    #1 check_zero("rst_rel2");
    push(ea(0, 0), eb(1, 0)); tick("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
